door_lock_ctrl: RTL and testbench
=================================

Name: door_lock_ctrl

Overview:
Parametrised successor of the keypad door-lock top. It integrates into one registered FSM:
- N-digit keypad entry and password compare, with in-place password change.
- Wrong-attempt lockout and auto-relock timeout.
- Hold-to-toggle always-open mode.

It sits between the debounced keypad/button front end and the lock actuator and alert outputs.

Parameters:
DIGITS, 4, password length in BCD digits (entry/PW width = 4*DIGITS)
DEFAULT_PW, 16'h0000 (width 4*DIGITS), password loaded at reset
MAX_TRIES, 3, consecutive failed HASH attempts that trigger LOCKOUT
LOCKOUT_CYCLES, 1000, CLK cycles spent in LOCKOUT
RELOCK_CYCLES, 500, CLK cycles in UNLOCKED before automatic relock
HOLD_CYCLES, 8, consecutive OPEN_BUTTON-high cycles in UNLOCKED that toggle always-open

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
KEY_VALID  in  1  one-cycle strobe; KEY_CODE valid
KEY_CODE  in  4  digit 0-9; codes 10-15 ignored
STAR  in  1  one-cycle strobe, clear entry
HASH  in  1  one-cycle strobe, submit entry
OPEN_BUTTON  in  1  inside egress button, level
CLOSE_SENSOR  in  1  door-closed sensor, level
DISPLAY  out  4*DIGITS  entry buffer, newest digit in low nibble
ENTRY_CNT  out  $clog2(DIGITS+1)  digits entered, saturates at DIGITS
UNLOCK  out  1  lock released
ALWAYS_OPEN  out  1  always-open mode active
ALERT  out  1  high throughout LOCKOUT
PW_CHANGED  out  1  one-cycle pulse on successful password change

Behaviour:
Reset (RESET=0, async):
- state=LOCKED, PW=DEFAULT_PW.
- Buffer, ENTRY_CNT, try count, all timers, edge registers: 0.
- All outputs 0.

General:
- All outputs are registered; every event becomes visible on the cycle after the sampling edge.
- Rising edges of OPEN_BUTTON and CLOSE_SENSOR are detected internally against a previous-value register.

Entry path (states LOCKED and UNLOCKED):
- Per-cycle priority: STAR > HASH > KEY_VALID.
- STAR: buffer=0, ENTRY_CNT=0.
- KEY_VALID with code <=9 and ENTRY_CNT<DIGITS: buffer = {buffer[4*DIGITS-5:0], code}; ENTRY_CNT+1.
- KEY_VALID when full, or with code >9: ignored.
- HASH: evaluated as described per state below; buffer and ENTRY_CNT are cleared on every HASH.

LOCKED:
- HASH with ENTRY_CNT==DIGITS and buffer==PW: go to UNLOCKED; try count=0.
- Any other HASH: try count+1. If the new count reaches MAX_TRIES: go to LOCKOUT, ALERT=1, try count=0.
- OPEN_BUTTON rising edge: go to UNLOCKED.
- Correct HASH together with an OPEN_BUTTON edge: go to UNLOCKED; try count=0.

UNLOCKED:
- UNLOCK=1. Relock timer counts from 0 each cycle.
- CLOSE_SENSOR rising edge: go to LOCKED.
- Timer reaches RELOCK_CYCLES-1: go to LOCKED.
- OPEN_BUTTON rising edge: restart the timer. If it coincides with a CLOSE_SENSOR rising edge, OPEN wins (remain UNLOCKED).
- HASH with ENTRY_CNT==DIGITS: PW=buffer, PW_CHANGED=1 for one cycle. HASH with ENTRY_CNT<DIGITS: clears entry only.
- Hold counter increments while OPEN_BUTTON=1 and clears when it is 0. On reaching HOLD_CYCLES: toggle ALWAYS_OPEN, clear the counter. The counter must fall back to 0 before another toggle can occur.

ALWAYS_OPEN=1:
- UNLOCK=1 in every state; the timer and CLOSE_SENSOR do not relock.
- Clearing it, via another HOLD_CYCLES hold in UNLOCKED, restarts the relock timer.

LOCKOUT:
- ALERT=1. STAR, HASH and KEY_VALID are ignored; buffer is held at 0.
- Counter reaches LOCKOUT_CYCLES-1: go to LOCKED, ALERT=0.
- OPEN_BUTTON rising edge: go to UNLOCKED, ALERT=0 (egress is always allowed).

Reset mid-operation: forces LOCKED and DEFAULT_PW immediately. A changed password is not retained.

Counter widths: $clog2 of the respective cycle parameter. Counters must never wrap.

Decomposition:
- Package door_lock_pkg holds:
  - state enum (LOCKED, UNLOCKED, LOCKOUT);
  - DIGIT_W=4 constant;
  - a function to compute counter width.
- One sub-module, keypad_entry: owns the buffer and ENTRY_CNT and resolves STAR/HASH/KEY priority. It takes a clear input from the FSM and outputs buffer, count and full.
- The FSM, PW register, timers and edge detection stay in door_lock_ctrl.

Test Plan:
(Parameters for all scenarios: DIGITS=4, DEFAULT_PW=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=20, RELOCK_CYCLES=10, HOLD_CYCLES=8.)
1. Keys 1,2,3,4, then HASH -> DISPLAY=16'h1234 before HASH; UNLOCK=1 next cycle; DISPLAY=0; UNLOCK returns to 0 exactly 10 cycles later.
2. Three HASHes, each after keys 9,9,9,9 -> UNLOCK stays 0; ALERT=1 after the third; ALERT drops and state is LOCKED 20 cycles later; keys during lockout leave DISPLAY=0.
3. Keys 1,2,3,4,5 -> 5th key ignored, ENTRY_CNT=4; STAR -> DISPLAY=0, ENTRY_CNT=0; key code 12 -> ignored.
4. Unlock, enter 5,6,7,8, HASH -> PW_CHANGED pulses for one cycle; after relock, 1,2,3,4,HASH fails and 5,6,7,8,HASH unlocks; assert RESET=0 -> 1,2,3,4 works again.
5. In UNLOCKED, OPEN_BUTTON high for 8 cycles -> ALWAYS_OPEN=1; CLOSE_SENSOR edge and 30 idle cycles keep UNLOCK=1; hold for 8 more cycles -> ALWAYS_OPEN=0; relock 10 cycles later.
6. In UNLOCKED, CLOSE_SENSOR and OPEN_BUTTON rise in the same cycle -> stays UNLOCKED, timer restarted; OPEN_BUTTON edge during LOCKOUT -> UNLOCK=1, ALERT=0 next cycle.

Source files
------------

// File: rtl/door_lock_pkg.sv
// Shared definitions for the keypad door-lock controller.
//   state_t   : controller FSM states
//   DIGIT_W   : width of one BCD keypad digit
//   cnt_width : register width needed to count 0 .. n-1 (never below 1)
package door_lock_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        LOCKED,
        UNLOCKED,
        LOCKOUT
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/door_lock_ctrl_keypad_entry.sv
// Keypad entry buffer for the door-lock controller.
// Collects up to DIGITS BCD digits, newest digit in the low nibble.
// Per-cycle priority: clear > star > hash > key_valid.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_valid   : one-cycle strobe, key_code valid (codes above 9 ignored)
//   key_code    : keypad digit
//   star, hash  : one-cycle strobes; both empty the buffer
//   clear       : FSM-forced clear, blocks all entry while high
//   buffer      : registered digit buffer
//   count       : digits entered, saturates at DIGITS
//   full        : count == DIGITS
module keypad_entry
    import door_lock_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned W      = DIGIT_W * DIGITS,
    localparam int unsigned CW     = $clog2(DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               star,
    input  logic               hash,
    input  logic               clear,
    output logic [W-1:0]       buffer,
    output logic [CW-1:0]      count,
    output logic               full
);

    logic [W-1:0]         buf_d;
    logic [CW-1:0]        cnt_d;
    logic [W+DIGIT_W-1:0] shifted;

    assign full = (count == CW'(DIGITS));

    always_comb begin
        buf_d   = buffer;
        cnt_d   = count;
        // Concatenate then truncate so a single-digit build needs no special slice.
        shifted = {buffer, key_code};
        if (clear || star || hash) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (key_valid && (key_code <= DIGIT_W'(9)) && !full) begin
            buf_d = shifted[W-1:0];
            cnt_d = count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
            count  <= '0;
        end else begin
            buffer <= buf_d;
            count  <= cnt_d;
        end
    end

endmodule

// File: rtl/door_lock_ctrl.sv
// Keypad door-lock controller: password entry/compare with in-place change,
// wrong-attempt lockout, auto-relock timeout and hold-to-toggle always-open.
// Ports:
//   CLK, RESET         : clock, asynchronous active-low reset
//   KEY_VALID/KEY_CODE : keypad digit strobe and code
//   STAR, HASH         : clear / submit strobes
//   OPEN_BUTTON        : inside egress button (level)
//   CLOSE_SENSOR       : door-closed sensor (level)
//   DISPLAY, ENTRY_CNT : entry buffer and digit count
//   UNLOCK             : lock released
//   ALWAYS_OPEN        : always-open mode active
//   ALERT              : high throughout lockout
//   PW_CHANGED         : one-cycle pulse on password change
// All outputs are registered.
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int unsigned                 DIGITS         = 4,
    parameter logic [DIGIT_W*DIGITS-1:0]   DEFAULT_PW     = '0,
    parameter int unsigned                 MAX_TRIES      = 3,
    parameter int unsigned                 LOCKOUT_CYCLES = 1000,
    parameter int unsigned                 RELOCK_CYCLES  = 500,
    parameter int unsigned                 HOLD_CYCLES    = 8
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          KEY_VALID,
    input  logic [DIGIT_W-1:0]            KEY_CODE,
    input  logic                          STAR,
    input  logic                          HASH,
    input  logic                          OPEN_BUTTON,
    input  logic                          CLOSE_SENSOR,
    output logic [DIGIT_W*DIGITS-1:0]     DISPLAY,
    output logic [$clog2(DIGITS+1)-1:0]   ENTRY_CNT,
    output logic                          UNLOCK,
    output logic                          ALWAYS_OPEN,
    output logic                          ALERT,
    output logic                          PW_CHANGED
);

    localparam int unsigned W  = DIGIT_W * DIGITS;
    localparam int unsigned TW = cnt_width(MAX_TRIES);
    localparam int unsigned LW = cnt_width(LOCKOUT_CYCLES);
    localparam int unsigned RW = cnt_width(RELOCK_CYCLES);
    localparam int unsigned HW = cnt_width(HOLD_CYCLES);

    localparam logic [TW-1:0] TRY_LAST    = TW'(MAX_TRIES - 1);
    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [RW-1:0] RELOCK_LAST = RW'(RELOCK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  pw_q, pw_d;
    logic [TW-1:0] try_q, try_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [RW-1:0] relock_q, relock_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          hold_done_q, hold_done_d;
    logic          ao_d;
    logic          pwch_d;
    logic          open_prev_q, close_prev_q;

    logic          open_rise, close_rise;
    logic          hash_go;
    logic          entry_clear;
    logic          entry_full;

    assign open_rise   = OPEN_BUTTON  && !open_prev_q;
    assign close_rise  = CLOSE_SENSOR && !close_prev_q;
    assign entry_clear = (state_q == LOCKOUT);
    // STAR outranks HASH; nothing is submitted during lockout.
    assign hash_go     = HASH && !STAR && (state_q != LOCKOUT);

    keypad_entry #(
        .DIGITS(DIGITS)
    ) u_entry (
        .clk      (CLK),
        .rst_n    (RESET),
        .key_valid(KEY_VALID),
        .key_code (KEY_CODE),
        .star     (STAR),
        .hash     (HASH),
        .clear    (entry_clear),
        .buffer   (DISPLAY),
        .count    (ENTRY_CNT),
        .full     (entry_full)
    );

    always_comb begin
        state_d     = state_q;
        pw_d        = pw_q;
        try_d       = try_q;
        lock_d      = '0;
        relock_d    = '0;
        hold_d      = '0;
        hold_done_d = 1'b0;
        ao_d        = ALWAYS_OPEN;
        pwch_d      = 1'b0;

        case (state_q)
            LOCKED: begin
                if (hash_go && entry_full && (DISPLAY == pw_q)) begin
                    state_d = UNLOCKED;
                    try_d   = '0;
                end else if (open_rise) begin
                    state_d = UNLOCKED;
                end else if (hash_go) begin
                    if (try_q == TRY_LAST) begin
                        state_d = LOCKOUT;
                        try_d   = '0;
                    end else begin
                        try_d = try_q + TW'(1);
                    end
                end
            end

            UNLOCKED: begin
                // After a toggle the button must be released before counting resumes.
                hold_d      = hold_q;
                hold_done_d = hold_done_q;
                if (!OPEN_BUTTON) begin
                    hold_d      = '0;
                    hold_done_d = 1'b0;
                end else if (!hold_done_q) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d      = '0;
                        hold_done_d = 1'b1;
                        ao_d        = !ALWAYS_OPEN;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end

                if (hash_go && entry_full) begin
                    pw_d   = DISPLAY;
                    pwch_d = 1'b1;
                end

                // Timer is parked at 0 while always-open is (or becomes) active,
                // so leaving always-open starts a full relock period.
                if (open_rise || ALWAYS_OPEN || ao_d) begin
                    relock_d = '0;
                end else if (close_rise || (relock_q == RELOCK_LAST)) begin
                    state_d = LOCKED;
                end else begin
                    relock_d = relock_q + RW'(1);
                end
            end

            LOCKOUT: begin
                if (open_rise) begin
                    state_d = UNLOCKED;
                end else if (lock_q == LOCK_LAST) begin
                    state_d = LOCKED;
                end else begin
                    lock_d = lock_q + LW'(1);
                end
            end

            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= LOCKED;
            pw_q         <= DEFAULT_PW;
            try_q        <= '0;
            lock_q       <= '0;
            relock_q     <= '0;
            hold_q       <= '0;
            hold_done_q  <= 1'b0;
            open_prev_q  <= 1'b0;
            close_prev_q <= 1'b0;
            UNLOCK       <= 1'b0;
            ALWAYS_OPEN  <= 1'b0;
            ALERT        <= 1'b0;
            PW_CHANGED   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pw_q         <= pw_d;
            try_q        <= try_d;
            lock_q       <= lock_d;
            relock_q     <= relock_d;
            hold_q       <= hold_d;
            hold_done_q  <= hold_done_d;
            open_prev_q  <= OPEN_BUTTON;
            close_prev_q <= CLOSE_SENSOR;
            UNLOCK       <= (state_d == UNLOCKED) || ao_d;
            ALWAYS_OPEN  <= ao_d;
            ALERT        <= (state_d == LOCKOUT);
            PW_CHANGED   <= pwch_d;
        end
    end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Self-checking bench for door_lock_ctrl with a behavioural reference model.
module tb_door_lock_ctrl;

    localparam int          DIG = 4;
    localparam logic [15:0] PW0 = 16'h1234;
    localparam int          MT  = 3;
    localparam int          LC  = 20;
    localparam int          RC  = 10;
    localparam int          HC  = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        KEY_VALID = 1'b0;
    logic [3:0]  KEY_CODE = 4'd0;
    logic        STAR = 1'b0;
    logic        HASH = 1'b0;
    logic        OPEN_BUTTON = 1'b0;
    logic        CLOSE_SENSOR = 1'b0;
    logic [15:0] DISPLAY;
    logic [2:0]  ENTRY_CNT;
    logic        UNLOCK, ALWAYS_OPEN, ALERT, PW_CHANGED;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    door_lock_ctrl #(
        .DIGITS        (DIG),
        .DEFAULT_PW    (PW0),
        .MAX_TRIES     (MT),
        .LOCKOUT_CYCLES(LC),
        .RELOCK_CYCLES (RC),
        .HOLD_CYCLES   (HC)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .KEY_VALID   (KEY_VALID),
        .KEY_CODE    (KEY_CODE),
        .STAR        (STAR),
        .HASH        (HASH),
        .OPEN_BUTTON (OPEN_BUTTON),
        .CLOSE_SENSOR(CLOSE_SENSOR),
        .DISPLAY     (DISPLAY),
        .ENTRY_CNT   (ENTRY_CNT),
        .UNLOCK      (UNLOCK),
        .ALWAYS_OPEN (ALWAYS_OPEN),
        .ALERT       (ALERT),
        .PW_CHANGED  (PW_CHANGED)
    );

    // ---------------- reference model ----------------
    // mode: 0 locked, 1 unlocked, 2 lockout. Digits kept as a list, timers
    // as "cycles remaining" in the current mode.
    int          m_mode;
    int          m_digits[$];
    logic [15:0] m_pw;
    int          m_tries, m_rleft, m_lleft, m_run;
    bit          m_latched, m_ao, m_oprev, m_cprev, m_pwch;

    function automatic logic [15:0] digits_value();
        logic [15:0] v;
        v = 16'h0;
        foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_digits.delete();
        m_pw = PW0;
        m_tries = 0; m_rleft = 0; m_lleft = 0; m_run = 0;
        m_latched = 0; m_ao = 0; m_oprev = 0; m_cprev = 0; m_pwch = 0;
    endfunction

    function automatic void model_step(input bit kv, input logic [3:0] kc, input bit st,
                                       input bit hs, input bit ob, input bit cs);
        bit orise, crise, hok, full, ao_old;
        logic [15:0] val;
        int old;
        orise  = ob && !m_oprev;
        crise  = cs && !m_cprev;
        old    = m_mode;
        hok    = hs && !st && (old != 2);
        full   = (m_digits.size() == DIG);
        val    = digits_value();
        ao_old = m_ao;
        m_pwch = 0;
        if (old == 0) begin
            if (hok && full && val == m_pw) begin m_mode = 1; m_tries = 0; m_rleft = RC; end
            else if (orise) begin m_mode = 1; m_rleft = RC; end
            else if (hok) begin
                m_tries++;
                if (m_tries == MT) begin m_mode = 2; m_tries = 0; m_lleft = LC; end
            end
        end else if (old == 1) begin
            if (!ob) begin m_run = 0; m_latched = 0; end
            else if (!m_latched) begin
                m_run++;
                if (m_run == HC) begin m_ao = !m_ao; m_run = 0; m_latched = 1; end
            end
            if (hok && full) begin m_pw = val; m_pwch = 1; end
            if (orise || ao_old || m_ao) m_rleft = RC;
            else if (crise) m_mode = 0;
            else begin m_rleft--; if (m_rleft == 0) m_mode = 0; end
        end else begin
            if (orise) begin m_mode = 1; m_rleft = RC; end
            else begin m_lleft--; if (m_lleft == 0) m_mode = 0; end
        end
        if (old != 1) begin m_run = 0; m_latched = 0; end
        if (old == 2 || st || hs) m_digits.delete();
        else if (kv && kc <= 4'd9 && m_digits.size() < DIG) m_digits.push_back(int'(kc));
        m_oprev = ob;
        m_cprev = cs;
    endfunction

    function automatic logic [22:0] model_vec();
        return {digits_value(), 3'(m_digits.size()), (m_mode == 1) || m_ao, m_ao,
                m_mode == 2, m_pwch};
    endfunction

    function automatic logic [22:0] dut_vec();
        return {DISPLAY, ENTRY_CNT, UNLOCK, ALWAYS_OPEN, ALERT, PW_CHANGED};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick();
        @(posedge CLK);
        if (RESET) model_step(KEY_VALID, KEY_CODE, STAR, HASH, OPEN_BUTTON, CLOSE_SENSOR);
        else model_reset();
        #1;
    endtask

    task automatic key(input int k);
        KEY_VALID = 1'b1; KEY_CODE = 4'(k); tick(); KEY_VALID = 1'b0;
    endtask

    task automatic hash();
        HASH = 1'b1; tick(); HASH = 1'b0;
    endtask

    task automatic star();
        STAR = 1'b1; tick(); STAR = 1'b0;
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 RESET = 1'b0;
        model_reset();
        #2;
        total++;
        if (dut_vec() !== 23'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), 23'd0);
        end
        tick(); tick();
        RESET = 1'b1;
        tick();
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL reset_release: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_unlock();
        int n;
        enter4(1, 2, 3, 4);
        total++;
        if (DISPLAY !== 16'h1234) begin
            bad++; $display("FAIL unlock_display: got %h want %h", DISPLAY, 16'h1234);
        end
        hash();
        total++;
        if (UNLOCK !== 1'b1 || DISPLAY !== 16'h0) begin
            bad++; $display("FAIL unlock_after_hash: got unlock=%b disp=%h want 1/0000", UNLOCK, DISPLAY);
        end
        n = 0;
        while (UNLOCK === 1'b1 && n < 50) begin
            tick(); n++;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL unlock_hold: got %h want %h", dut_vec(), model_vec());
            end
        end
        total++;
        if (n !== RC) begin
            bad++; $display("FAIL unlock_relock_len: got %0d want %0d", n, RC);
        end
    endtask

    task automatic test_lockout();
        int n;
        bit exp_alert;
        for (int a = 0; a < 3; a++) begin
            enter4(9, 9, 9, 9);
            hash();
            exp_alert = (a == 2);
            total++;
            if (UNLOCK !== 1'b0 || ALERT !== exp_alert) begin
                bad++; $display("FAIL lockout_attempt%0d: got unlock=%b alert=%b want 0/%b",
                                a, UNLOCK, ALERT, exp_alert);
            end
        end
        n = 0;
        while (ALERT === 1'b1 && n < 60) begin
            if (n < 6) begin
                KEY_VALID = 1'b1; KEY_CODE = 4'($urandom_range(0, 9));
                STAR = (n == 3); HASH = (n == 4);
            end
            tick(); n++;
            KEY_VALID = 1'b0; STAR = 1'b0; HASH = 1'b0;
            total++;
            if (DISPLAY !== 16'h0 || ENTRY_CNT !== 3'd0) begin
                bad++; $display("FAIL lockout_keys: got disp=%h cnt=%0d want 0/0", DISPLAY, ENTRY_CNT);
            end
        end
        total++;
        if (n !== LC) begin
            bad++; $display("FAIL lockout_len: got %0d want %0d", n, LC);
        end
        total++;
        if (dut_vec() !== model_vec() || UNLOCK !== 1'b0) begin
            bad++; $display("FAIL lockout_exit: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_entry_limits();
        int d;
        for (int i = 1; i <= 5; i++) key(i);
        total++;
        if (ENTRY_CNT !== 3'd4 || DISPLAY !== 16'h1234) begin
            bad++; $display("FAIL entry_full: got cnt=%0d disp=%h want 4/1234", ENTRY_CNT, DISPLAY);
        end
        star();
        total++;
        if (ENTRY_CNT !== 3'd0 || DISPLAY !== 16'h0) begin
            bad++; $display("FAIL entry_star: got cnt=%0d disp=%h want 0/0000", ENTRY_CNT, DISPLAY);
        end
        key(12);
        total++;
        if (ENTRY_CNT !== 3'd0) begin
            bad++; $display("FAIL entry_code12: got cnt=%0d want 0", ENTRY_CNT);
        end
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 15);
            key(d);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL entry_random key=%0d: got %h want %h", d, dut_vec(), model_vec());
            end
        end
        STAR = 1'b1; HASH = 1'b1; tick(); STAR = 1'b0; HASH = 1'b0;
        total++;
        if (dut_vec() !== model_vec() || ENTRY_CNT !== 3'd0) begin
            bad++; $display("FAIL entry_star_hash: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic wait_relock(input string tag);
        int n;
        n = 0;
        while (UNLOCK === 1'b1 && n < 40) begin tick(); n++; end
        total++;
        if (UNLOCK !== 1'b0) begin
            bad++; $display("FAIL %s_relock_timeout: got unlock=%b want 0", tag, UNLOCK);
        end
    endtask

    task automatic test_pw_change();
        enter4(1, 2, 3, 4); hash();
        enter4(5, 6, 7, 8); hash();
        total++;
        if (PW_CHANGED !== 1'b1 || UNLOCK !== 1'b1) begin
            bad++; $display("FAIL pw_change_pulse: got pwch=%b unlock=%b want 1/1", PW_CHANGED, UNLOCK);
        end
        tick();
        total++;
        if (PW_CHANGED !== 1'b0) begin
            bad++; $display("FAIL pw_change_width: got %b want 0", PW_CHANGED);
        end
        wait_relock("pw");
        enter4(1, 2, 3, 4); hash();
        total++;
        if (UNLOCK !== 1'b0) begin
            bad++; $display("FAIL pw_old_rejected: got %b want 0", UNLOCK);
        end
        enter4(5, 6, 7, 8); hash();
        total++;
        if (UNLOCK !== 1'b1) begin
            bad++; $display("FAIL pw_new_accepted: got %b want 1", UNLOCK);
        end
        RESET = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== 23'd0) begin
            bad++; $display("FAIL pw_midreset: got %h want %h", dut_vec(), 23'd0);
        end
        tick();
        RESET = 1'b1;
        enter4(1, 2, 3, 4); hash();
        total++;
        if (UNLOCK !== 1'b1 || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL pw_default_restored: got %h want %h", dut_vec(), model_vec());
        end
        wait_relock("pw2");
    endtask

    task automatic test_always_open();
        int n;
        enter4(1, 2, 3, 4); hash();
        OPEN_BUTTON = 1'b1;
        for (int i = 0; i < HC; i++) begin
            tick();
            total++;
            if (ALWAYS_OPEN !== (i == HC - 1)) begin
                bad++; $display("FAIL ao_on_hold%0d: got %b want %b", i, ALWAYS_OPEN, i == HC - 1);
            end
        end
        OPEN_BUTTON = 1'b0; tick();
        CLOSE_SENSOR = 1'b1; tick(); CLOSE_SENSOR = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if (UNLOCK !== 1'b1 || dut_vec() !== model_vec()) begin
                bad++; $display("FAIL ao_idle%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        OPEN_BUTTON = 1'b1;
        for (int i = 0; i < HC; i++) begin
            tick();
            total++;
            if (ALWAYS_OPEN !== (i != HC - 1)) begin
                bad++; $display("FAIL ao_off_hold%0d: got %b want %b", i, ALWAYS_OPEN, i != HC - 1);
            end
        end
        OPEN_BUTTON = 1'b0;
        n = 0;
        while (UNLOCK === 1'b1 && n < 40) begin tick(); n++; end
        total++;
        if (n !== RC) begin
            bad++; $display("FAIL ao_relock_len: got %0d want %0d", n, RC);
        end
    endtask

    task automatic test_edges();
        int n;
        enter4(1, 2, 3, 4); hash();
        tick(); tick(); tick();
        OPEN_BUTTON = 1'b1; CLOSE_SENSOR = 1'b1; tick(); OPEN_BUTTON = 1'b0;
        total++;
        if (UNLOCK !== 1'b1) begin
            bad++; $display("FAIL edge_open_wins: got %b want 1", UNLOCK);
        end
        n = 0;
        while (UNLOCK === 1'b1 && n < 40) begin tick(); n++; end
        total++;
        if (n !== RC) begin
            bad++; $display("FAIL edge_timer_restart: got %0d want %0d", n, RC);
        end
        CLOSE_SENSOR = 1'b0;
        for (int a = 0; a < 3; a++) begin
            enter4(9, 9, 9, 9); hash();
        end
        total++;
        if (ALERT !== 1'b1) begin
            bad++; $display("FAIL edge_lockout_entry: got %b want 1", ALERT);
        end
        tick(); tick();
        OPEN_BUTTON = 1'b1; tick(); OPEN_BUTTON = 1'b0;
        total++;
        if (UNLOCK !== 1'b1 || ALERT !== 1'b0) begin
            bad++; $display("FAIL edge_egress: got unlock=%b alert=%b want 1/0", UNLOCK, ALERT);
        end
        wait_relock("edge");
    endtask

    task automatic test_random();
        int r, sz;
        for (int c = 0; c < 1500; c++) begin
            r  = $urandom_range(0, 99);
            sz = m_digits.size();
            KEY_VALID = (r < 45);
            if ($urandom_range(0, 9) < 7 && sz < DIG) KEY_CODE = m_pw[(DIG-1-sz)*4 +: 4];
            else KEY_CODE = 4'($urandom_range(0, 15));
            STAR = (r >= 45 && r < 48);
            HASH = (r >= 48 && r < 58);
            if ($urandom_range(0, 19) == 0) OPEN_BUTTON = ~OPEN_BUTTON;
            CLOSE_SENSOR = ($urandom_range(0, 24) == 0);
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec(), model_vec());
            end
        end
        KEY_VALID = 1'b0; STAR = 1'b0; HASH = 1'b0; OPEN_BUTTON = 1'b0; CLOSE_SENSOR = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_unlock();
        test_lockout();
        test_entry_limits();
        test_pw_change();
        test_always_open();
        test_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
